// File: rtl/tile_config_mem_ff.sv
// tile_config_mem_ff: flop-based shadow/active configuration store for an eFPGA tile.
// Optional registered frame readback of the active store is enabled by defining CONFIG_READBACK_EN.
module tile_config_mem_ff #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigBits    = 64,
  localparam int NUM_FRAMES = (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow,
  localparam int SEL_W      = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  input  logic                       Commit,
  output logic [NoConfigBits-1:0]    ConfigBits,
  output logic [NUM_FRAMES-1:0]      Pending,
  output logic                       AllWritten,
  output logic                       CommitAck,
  input  logic [SEL_W-1:0]           ReadbackSel,
  output logic [FrameBitsPerRow-1:0] ReadbackData
);
  localparam int PAD_W = NUM_FRAMES * FrameBitsPerRow;
  logic [NUM_FRAMES-1:0]   strobeQ;
  logic [NUM_FRAMES-1:0]   strobeEdge;
  logic [NUM_FRAMES-1:0]   pendingQ;
  logic [NoConfigBits-1:0] shadow;
  logic [NoConfigBits-1:0] active;
  logic                    unusedIn;
  // Strobes for frames beyond the store never reach any logic.
  assign unusedIn   = ^{FrameStrobe, FrameData};
  assign strobeEdge = FrameStrobe[NUM_FRAMES-1:0] & ~strobeQ;
  assign ConfigBits = active;
  assign Pending    = pendingQ;
  assign AllWritten = &pendingQ;
  // strobeQ resets high so a strobe already asserted at reset release is not an edge.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      strobeQ   <= '1;
      pendingQ  <= '0;
      shadow    <= '0;
      active    <= '0;
      CommitAck <= 1'b0;
    end else begin
      strobeQ   <= FrameStrobe[NUM_FRAMES-1:0];
      pendingQ  <= (Commit ? '0 : pendingQ) | strobeEdge;
      CommitAck <= Commit;
      if (Commit) active <= shadow;
      for (int i = 0; i < NoConfigBits; i++)
        if (strobeEdge[i / FrameBitsPerRow]) shadow[i] <= FrameData[i % FrameBitsPerRow];
    end
  end
`ifdef CONFIG_READBACK_EN
  logic [PAD_W-1:0]           activePad;
  logic [FrameBitsPerRow-1:0] rbNext;
  always_comb begin
    activePad = PAD_W'(active);
    rbNext    = '0;
    for (int f = 0; f < NUM_FRAMES; f++)
      rbNext = (32'(ReadbackSel) == f) ? activePad[f*FrameBitsPerRow +: FrameBitsPerRow] : rbNext;
  end
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) ReadbackData <= '0;
    else ReadbackData <= rbNext;
  end
`else
  logic unusedSel;
  assign unusedSel    = ^ReadbackSel;
  assign ReadbackData = '0;
`endif
endmodule

// File: tb/tb_tile_config_mem_ff.sv
// tb_tile_config_mem_ff: directed and random checks of tile_config_mem_ff against a frame-level model.
module tb_tile_config_mem_ff;
  localparam int MF = 20, FB = 32, NB = 72, NF = 3, SW = 5;
  logic          CLK = 0, resetn = 1, Commit = 0;
  logic [FB-1:0] FrameData = 0;
  logic [MF-1:0] FrameStrobe = 0;
  logic [SW-1:0] ReadbackSel = 0;
  logic [NB-1:0] ConfigBits;
  logic [NF-1:0] Pending;
  logic          AllWritten, CommitAck;
  logic [FB-1:0] ReadbackData;
  int nAsserts = 0, nFails = 0;
  logic [31:0] shM [NF];
  logic [31:0] actM [NF];
  logic [NF-1:0] pendM;
  logic [MF-1:0] strobeM;
  logic ackM;
  logic [31:0] rbM;

  tile_config_mem_ff #(.MaxFramesPerCol(MF), .FrameBitsPerRow(FB), .NoConfigBits(NB)) dut (
    .CLK(CLK), .resetn(resetn), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .Commit(Commit), .ConfigBits(ConfigBits), .Pending(Pending), .AllWritten(AllWritten),
    .CommitAck(CommitAck), .ReadbackSel(ReadbackSel), .ReadbackData(ReadbackData));

  always #5 CLK = ~CLK;

  function automatic logic [31:0] frameMask(int f);
    return (f == NF - 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [NB-1:0] expConfig();
    return {actM[2][7:0], actM[1], actM[0]};
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int f = 0; f < NF; f++) begin shM[f] = 0; actM[f] = 0; end
    pendM = 0; strobeM = '1; ackM = 0; rbM = 0;
  endtask

  task automatic checkAll(string tag);
    chk({tag, ".cfg"}, 128'(ConfigBits), 128'(expConfig()));
    chk({tag, ".pend"}, 128'(Pending), 128'(pendM));
    chk({tag, ".all"}, 128'(AllWritten), 128'(&pendM));
    chk({tag, ".ack"}, 128'(CommitAck), 128'(ackM));
    chk({tag, ".rb"}, 128'(ReadbackData), 128'(rbM));
  endtask

  task automatic tick(string tag);
    logic [MF-1:0] edges;
    logic [31:0] oldAct [NF];
    @(posedge CLK);
    #1;
    if (!resetn) resetModel();
    else begin
      edges = FrameStrobe & ~strobeM;
      strobeM = FrameStrobe;
      for (int f = 0; f < NF; f++) oldAct[f] = actM[f];
      if (Commit) begin
        for (int f = 0; f < NF; f++) actM[f] = shM[f];
        pendM = 0;
      end
      for (int f = 0; f < NF; f++)
        if (edges[f]) begin shM[f] = FrameData & frameMask(f); pendM[f] = 1'b1; end
      ackM = Commit;
`ifdef CONFIG_READBACK_EN
      rbM = (int'(ReadbackSel) < NF) ? oldAct[ReadbackSel] : 32'h0;
`else
      rbM = 32'h0;
`endif
    end
    checkAll(tag);
  endtask

  task automatic drive(logic [MF-1:0] s, logic [FB-1:0] d, logic c);
    FrameStrobe = s; FrameData = d; Commit = c;
  endtask

  initial begin
    resetModel();
    // 1: async reset with random inputs
    #2;
    FrameData = $urandom; FrameStrobe = MF'($urandom); Commit = 1'b1; ReadbackSel = SW'($urandom);
    resetn = 0;
    #1;
    resetModel();
    checkAll("reset_async");
    tick("reset_held");
    tick("reset_held2");
    drive('0, 0, 0); ReadbackSel = 0;
    @(negedge CLK); resetn = 1;
    tick("release");
    // 2: load three frames then commit
    drive(20'h1, 32'hDEADBEEF, 0); tick("load_f0");
    drive(20'h2, 32'h12345678, 0); tick("load_f1");
    drive(20'h4, 32'hFFFFFFA5, 0); tick("load_f2");
    drive(20'h0, 32'h0, 0); tick("load_idle");
    chk("pending_all", 128'(Pending), 128'(3'b111));
    chk("cfg_before_commit", 128'(ConfigBits), 128'(0));
    drive(0, 0, 1); tick("commit1");
    chk("cfg_commit1", 128'(ConfigBits), 128'(72'hA5_12345678_DEADBEEF));
    chk("ack_commit1", 128'(CommitAck), 128'(1));
    drive(0, 0, 0); tick("commit1_after");
    chk("ack_drop", 128'(CommitAck), 128'(0));
    // 3: held strobe captures once
    for (int k = 1; k <= 5; k++) begin drive(20'h2, 32'(k), 0); tick("hold_f1"); end
    drive(0, 0, 1); tick("commit_hold");
    chk("cfg_hold", 128'(ConfigBits[63:32]), 128'(32'h1));
    // 4: strobe beyond stored frames ignored
    drive(20'h80, 32'hFFFFFFFF, 0); tick("f7_pulse");
    chk("pend_f7", 128'(Pending), 128'(0));
    drive(0, 0, 1); tick("commit_f7");
    chk("cfg_f7", 128'(ConfigBits), 128'(72'hA5_00000001_DEADBEEF));
    // 5: commit with simultaneous edge
    drive(20'h2, 32'hAAAAAAAA, 1); tick("commit_edge");
    chk("cfg_old_f1", 128'(ConfigBits[63:32]), 128'(32'h1));
    chk("pend_f1", 128'(Pending), 128'(3'b010));
    drive(0, 0, 1); tick("commit2");
    chk("cfg_new_f1", 128'(ConfigBits[63:32]), 128'(32'hAAAAAAAA));
    tick("commit_held");
    chk("ack_held", 128'(CommitAck), 128'(1));
    // 6: strobe high through reset release does not capture
    drive(20'h7, 32'h55555555, 0);
    @(negedge CLK); resetn = 0; #1; resetModel(); checkAll("reset2");
    @(negedge CLK); resetn = 1;
    tick("rel_strobe");
    tick("rel_strobe2");
    chk("pend_no_capture", 128'(Pending), 128'(0));
    drive(0, 0, 0); tick("idle");
    drive(20'h2, 32'h12345678, 0); tick("rb_f1");
    drive(20'h4, 32'hFFFFFFA5, 0); tick("rb_f2");
    drive(0, 0, 1); tick("rb_commit");
    drive(0, 0, 0);
    ReadbackSel = 1; tick("rb_sel1");
    ReadbackSel = 2; tick("rb_sel2");
`ifdef CONFIG_READBACK_EN
    chk("rb_sel2_val", 128'(ReadbackData), 128'(32'h000000A5));
`else
    chk("rb_tied", 128'(ReadbackData), 128'(0));
`endif
    ReadbackSel = 5; tick("rb_sel5");
    chk("rb_sel5_val", 128'(ReadbackData), 128'(0));
    // random traffic
    for (int n = 0; n < 400; n++) begin
      FrameStrobe = ($urandom_range(0, 2) == 0) ? MF'($urandom) : MF'($urandom_range(0, 7));
      FrameData = $urandom;
      Commit = ($urandom_range(0, 3) == 0);
      ReadbackSel = SW'($urandom_range(0, 7));
      tick("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
